// File: rtl/prog_ctrl.sv
// prog_ctrl: program-memory arbiter and run/step controller.
//
// A single-port instruction memory is shared between the CPU fetch port and
// a debug port. The CPU owns the memory while running (RUN) or single-stepping
// (STEP). The debug port owns it only while halted (HALT).
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   run_i, step_i       free-run level / single-fetch pulse
//   cpu_ce_i/addr_i     CPU fetch request
//   cpu_data_o          fetched word (NOP_WORD when no fetch returns)
//   cpu_stall_o         CPU must hold while halted
//   dbg_*               debug access request / grant / read return
//   mem_*               single-port memory interface (1-cycle read latency)
//   halted_o            state is HALT
//   fetch_cnt_o         wrapping count of granted CPU fetches
//   state_o             raw FSM state for observation
//
// Handshake: a request is accepted in the same cycle its grant is high.
// Read data for an accepted read returns exactly one cycle later, and
// dbg_rvalid_o marks the debug read data. There is no back-pressure on
// the returned data.
module prog_ctrl #(
  parameter int unsigned          ADDR_W   = 16,
  parameter int unsigned          DATA_W   = 16,
  parameter logic [DATA_W-1:0]    NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_i,
  input  logic              step_i,
  input  logic              cpu_ce_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_rvalid_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              halted_o,
  output logic [15:0]       fetch_cnt_o,
  output logic [1:0]        state_o
);

  localparam logic [1:0] ST_HALT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        cpu_rd_q, cpu_rd_d;
  logic        dbg_rd_q, dbg_rd_d;
  logic [15:0] fetch_cnt_q, fetch_cnt_d;

  logic cpu_grant;
  logic dbg_grant;

  // Ownership follows the state, so the two grants can never both be high.
  assign cpu_grant = ((state_q == ST_RUN) || (state_q == ST_STEP)) && cpu_ce_i;
  assign dbg_grant = (state_q == ST_HALT) && dbg_req_i;

  // Next-state logic. A pending debug request blocks leaving HALT. A step
  // pulse that arrives while it is blocked is not remembered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALT: begin
        if (!dbg_req_i) begin
          if (run_i)       state_d = ST_RUN;
          else if (step_i) state_d = ST_STEP;
        end
      end
      ST_RUN:  if (!run_i) state_d = ST_HALT;
      ST_STEP: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  always_comb begin
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (cpu_grant) begin
      mem_ce_o   = 1'b1;
      mem_addr_o = cpu_addr_i;
    end else if (dbg_grant) begin
      mem_ce_o    = 1'b1;
      mem_we_o    = dbg_we_i;
      mem_addr_o  = dbg_addr_i;
      mem_wdata_o = dbg_wdata_i;
    end
  end

  assign cpu_rd_d    = cpu_grant;
  assign dbg_rd_d    = dbg_grant && !dbg_we_i;
  assign fetch_cnt_d = fetch_cnt_q + {15'd0, cpu_grant};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_HALT;
      cpu_rd_q    <= 1'b0;
      dbg_rd_q    <= 1'b0;
      fetch_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cpu_rd_q    <= cpu_rd_d;
      dbg_rd_q    <= dbg_rd_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // The return path depends only on the registered flags. This lets a fetch
  // issued in the last RUN/STEP cycle still reach the CPU once halted.
  assign cpu_data_o   = cpu_rd_q ? mem_rdata_i : NOP_WORD;
  assign dbg_rvalid_o = dbg_rd_q;
  assign dbg_rdata_o  = dbg_rd_q ? mem_rdata_i : '0;
  assign dbg_gnt_o    = dbg_grant;
  assign cpu_stall_o  = (state_q == ST_HALT);
  assign halted_o     = (state_q == ST_HALT);
  assign fetch_cnt_o  = fetch_cnt_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_prog_ctrl.sv
module tb_prog_ctrl;
  localparam logic [15:0] NOP = 16'hBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_i, step_i, cpu_ce_i;
  logic [15:0] cpu_addr_i;
  logic [15:0] cpu_data_o;
  logic        cpu_stall_o;
  logic        dbg_req_i, dbg_we_i;
  logic [15:0] dbg_addr_i, dbg_wdata_i;
  logic        dbg_gnt_o, dbg_rvalid_o;
  logic [15:0] dbg_rdata_o;
  logic        mem_ce_o, mem_we_o;
  logic [15:0] mem_addr_o, mem_wdata_o;
  logic [15:0] mem_rdata_i;
  logic        halted_o;
  logic [15:0] fetch_cnt_o;
  logic [1:0]  state_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem [0:65535];

  prog_ctrl #(.ADDR_W(16), .DATA_W(16), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .run_i(run_i), .step_i(step_i),
    .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i), .cpu_data_o(cpu_data_o),
    .cpu_stall_o(cpu_stall_o), .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i),
    .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i), .dbg_gnt_o(dbg_gnt_o),
    .dbg_rdata_o(dbg_rdata_o), .dbg_rvalid_o(dbg_rvalid_o),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .halted_o(halted_o), .fetch_cnt_o(fetch_cnt_o), .state_o(state_o)
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  // Behavioural single-port memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_ce_o) begin
      if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
      else          mem_rdata_i     <= mem[mem_addr_o];
    end
  end

  task automatic test_reset();
    rst = 1'b0; run_i = 0; step_i = 0; cpu_ce_i = 0; cpu_addr_i = 0;
    dbg_req_i = 0; dbg_we_i = 0; dbg_addr_i = 0; dbg_wdata_i = 0;
    @(negedge clk); #1;
    n_tests++; if (halted_o !== 1'b1) begin n_fail++; $display("FAIL reset_halted got %b exp 1", halted_o); end
    n_tests++; if (cpu_stall_o !== 1'b1) begin n_fail++; $display("FAIL reset_stall got %b exp 1", cpu_stall_o); end
    n_tests++; if (cpu_data_o !== NOP) begin n_fail++; $display("FAIL reset_cpu_data got %h exp %h", cpu_data_o, NOP); end
    n_tests++; if (dbg_gnt_o !== 1'b0 || dbg_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_dbg got gnt=%b rvalid=%b exp 0 0", dbg_gnt_o, dbg_rvalid_o); end
    n_tests++; if (mem_ce_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ce got %b exp 0", mem_ce_o); end
    n_tests++; if (fetch_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %h exp 0000", fetch_cnt_o); end
    // A debug request is granted combinationally even while reset is held.
    dbg_req_i = 1; dbg_addr_i = 16'h0005; #1;
    n_tests++; if (dbg_gnt_o !== 1'b1 || mem_ce_o !== 1'b1) begin n_fail++; $display("FAIL reset_dbg_grant got gnt=%b ce=%b exp 1 1", dbg_gnt_o, mem_ce_o); end
    dbg_req_i = 0; dbg_addr_i = 0;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_load();
    @(negedge clk); dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 16'h0000; dbg_wdata_i = 16'h3443; #1;
    n_tests++; if ({dbg_gnt_o, mem_ce_o, mem_we_o} !== 3'b111 || mem_addr_o !== 16'h0000 || mem_wdata_o !== 16'h3443)
      begin n_fail++; $display("FAIL load_wr0 got gnt/ce/we=%b addr=%h wd=%h exp 111 0000 3443", {dbg_gnt_o, mem_ce_o, mem_we_o}, mem_addr_o, mem_wdata_o); end
    n_tests++; if (cpu_stall_o !== 1'b1) begin n_fail++; $display("FAIL load_stall0 got %b exp 1", cpu_stall_o); end
    @(negedge clk); dbg_addr_i = 16'h0001; dbg_wdata_i = 16'h1234; #1;
    n_tests++; if ({dbg_gnt_o, mem_ce_o, mem_we_o} !== 3'b111 || mem_addr_o !== 16'h0001 || mem_wdata_o !== 16'h1234)
      begin n_fail++; $display("FAIL load_wr1 got gnt/ce/we=%b addr=%h wd=%h exp 111 0001 1234", {dbg_gnt_o, mem_ce_o, mem_we_o}, mem_addr_o, mem_wdata_o); end
    n_tests++; if (dbg_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL load_wr_no_rvalid got %b exp 0", dbg_rvalid_o); end
    @(negedge clk); dbg_we_i = 0; dbg_wdata_i = 0; #1;
    n_tests++; if ({dbg_gnt_o, mem_ce_o, mem_we_o} !== 3'b110 || mem_addr_o !== 16'h0001)
      begin n_fail++; $display("FAIL load_rd got gnt/ce/we=%b addr=%h exp 110 0001", {dbg_gnt_o, mem_ce_o, mem_we_o}, mem_addr_o); end
    n_tests++; if (dbg_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL load_wr1_no_rvalid got %b exp 0", dbg_rvalid_o); end
    @(negedge clk); dbg_req_i = 0; dbg_addr_i = 0; #1;
    n_tests++; if (dbg_rvalid_o !== 1'b1 || dbg_rdata_o !== 16'h1234) begin n_fail++; $display("FAIL load_rdata got v=%b d=%h exp 1 1234", dbg_rvalid_o, dbg_rdata_o); end
    n_tests++; if (dbg_gnt_o !== 1'b0 || mem_ce_o !== 1'b0 || cpu_stall_o !== 1'b1) begin n_fail++; $display("FAIL load_idle got gnt=%b ce=%b stall=%b exp 0 0 1", dbg_gnt_o, mem_ce_o, cpu_stall_o); end
    @(negedge clk); #1;
    n_tests++; if (dbg_rvalid_o !== 1'b0 || dbg_rdata_o !== 16'h0000) begin n_fail++; $display("FAIL load_rvalid_drop got v=%b d=%h exp 0 0000", dbg_rvalid_o, dbg_rdata_o); end
  endtask

  task automatic test_run();
    @(negedge clk); run_i = 1; cpu_ce_i = 1; cpu_addr_i = 16'h0000; #1;
    n_tests++; if (cpu_stall_o !== 1'b1 || mem_ce_o !== 1'b0) begin n_fail++; $display("FAIL run_pre got stall=%b ce=%b exp 1 0", cpu_stall_o, mem_ce_o); end
    @(negedge clk); #1;
    n_tests++; if (cpu_stall_o !== 1'b0 || halted_o !== 1'b0) begin n_fail++; $display("FAIL run_enter got stall=%b halted=%b exp 0 0", cpu_stall_o, halted_o); end
    n_tests++; if (mem_ce_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 16'h0000) begin n_fail++; $display("FAIL run_grant0 got ce=%b we=%b addr=%h exp 1 0 0000", mem_ce_o, mem_we_o, mem_addr_o); end
    n_tests++; if (cpu_data_o !== NOP) begin n_fail++; $display("FAIL run_first_nop got %h exp %h", cpu_data_o, NOP); end
    @(negedge clk); cpu_addr_i = 16'h0001; #1;
    n_tests++; if (cpu_data_o !== 16'h3443) begin n_fail++; $display("FAIL run_data0 got %h exp 3443", cpu_data_o); end
    @(negedge clk); cpu_addr_i = 16'h0002; #1;
    n_tests++; if (cpu_data_o !== 16'h1234) begin n_fail++; $display("FAIL run_data1 got %h exp 1234", cpu_data_o); end
    n_tests++; if (fetch_cnt_o !== 16'd2) begin n_fail++; $display("FAIL run_cnt2 got %h exp 0002", fetch_cnt_o); end
    // Last RUN cycle still fetches address 0; its word must arrive while halted.
    @(negedge clk); run_i = 0; cpu_addr_i = 16'h0000; #1;
    n_tests++; if (cpu_data_o !== 16'h0000) begin n_fail++; $display("FAIL run_data2 got %h exp 0000", cpu_data_o); end
    n_tests++; if (fetch_cnt_o !== 16'd3) begin n_fail++; $display("FAIL run_cnt3 got %h exp 0003", fetch_cnt_o); end
    @(negedge clk); cpu_ce_i = 0; #1;
    n_tests++; if (halted_o !== 1'b1 || cpu_data_o !== 16'h3443) begin n_fail++; $display("FAIL run_tail got halted=%b data=%h exp 1 3443", halted_o, cpu_data_o); end
    n_tests++; if (fetch_cnt_o !== 16'd4) begin n_fail++; $display("FAIL run_cnt4 got %h exp 0004", fetch_cnt_o); end
    @(negedge clk); #1;
    n_tests++; if (cpu_data_o !== NOP) begin n_fail++; $display("FAIL run_after_nop got %h exp %h", cpu_data_o, NOP); end
  endtask

  task automatic test_step();
    @(negedge clk); step_i = 1; cpu_ce_i = 1; cpu_addr_i = 16'h0000; #1;
    n_tests++; if (mem_ce_o !== 1'b0 || halted_o !== 1'b1) begin n_fail++; $display("FAIL step_pre got ce=%b halted=%b exp 0 1", mem_ce_o, halted_o); end
    @(negedge clk); step_i = 0; #1;
    n_tests++; if (halted_o !== 1'b0 || cpu_stall_o !== 1'b0 || mem_ce_o !== 1'b1 || state_o !== 2'd2)
      begin n_fail++; $display("FAIL step_active got halted=%b stall=%b ce=%b st=%0d exp 0 0 1 2", halted_o, cpu_stall_o, mem_ce_o, state_o); end
    @(negedge clk); #1;
    n_tests++; if (halted_o !== 1'b1 || mem_ce_o !== 1'b0) begin n_fail++; $display("FAIL step_back got halted=%b ce=%b exp 1 0", halted_o, mem_ce_o); end
    n_tests++; if (cpu_data_o !== 16'h3443) begin n_fail++; $display("FAIL step_data got %h exp 3443", cpu_data_o); end
    n_tests++; if (fetch_cnt_o !== 16'd5) begin n_fail++; $display("FAIL step_cnt got %h exp 0005", fetch_cnt_o); end
    @(negedge clk); #1;
    n_tests++; if (halted_o !== 1'b1 || mem_ce_o !== 1'b0 || cpu_data_o !== NOP) begin n_fail++; $display("FAIL step_once got halted=%b ce=%b data=%h exp 1 0 %h", halted_o, mem_ce_o, cpu_data_o, NOP); end
    cpu_ce_i = 0;
  endtask

  task automatic test_conflict();
    // The CPU wants address 2, but the debug read of address 1 must win.
    @(negedge clk); run_i = 1; cpu_ce_i = 1; cpu_addr_i = 16'h0002;
    dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (dbg_gnt_o !== 1'b1 || halted_o !== 1'b1 || mem_addr_o !== 16'h0001)
        begin n_fail++; $display("FAIL conflict_c%0d got gnt=%b halted=%b addr=%h exp 1 1 0001", i, dbg_gnt_o, halted_o, mem_addr_o); end
      @(negedge clk);
    end
    dbg_req_i = 0; #1;
    n_tests++; if (dbg_gnt_o !== 1'b0 || halted_o !== 1'b1 || dbg_rvalid_o !== 1'b1 || dbg_rdata_o !== 16'h1234)
      begin n_fail++; $display("FAIL conflict_release got gnt=%b halted=%b v=%b d=%h exp 0 1 1 1234", dbg_gnt_o, halted_o, dbg_rvalid_o, dbg_rdata_o); end
    n_tests++; if (fetch_cnt_o !== 16'd5) begin n_fail++; $display("FAIL conflict_no_cpu got %h exp 0005", fetch_cnt_o); end
    @(negedge clk); #1;
    n_tests++; if (halted_o !== 1'b0 || mem_addr_o !== 16'h0002) begin n_fail++; $display("FAIL conflict_run got halted=%b addr=%h exp 0 0002", halted_o, mem_addr_o); end
    run_i = 0; cpu_ce_i = 0;
    @(negedge clk); #1;
    n_tests++; if (halted_o !== 1'b1 || fetch_cnt_o !== 16'd5) begin n_fail++; $display("FAIL conflict_halt got halted=%b cnt=%h exp 1 0005", halted_o, fetch_cnt_o); end
    // A step pulse that meets a debug request is dropped, not deferred.
    @(negedge clk); step_i = 1; dbg_req_i = 1;
    @(negedge clk); step_i = 0; dbg_req_i = 0;
    @(negedge clk); #1;
    n_tests++; if (halted_o !== 1'b1 || mem_ce_o !== 1'b0) begin n_fail++; $display("FAIL step_dropped got halted=%b ce=%b exp 1 0", halted_o, mem_ce_o); end
  endtask

  task automatic test_wrap_reset();
    @(negedge clk); rst = 0; #1;
    n_tests++; if (fetch_cnt_o !== 16'd0) begin n_fail++; $display("FAIL wrap_clear got %h exp 0000", fetch_cnt_o); end
    @(negedge clk); rst = 1; run_i = 1; cpu_ce_i = 1; cpu_addr_i = 16'h0000;
    @(negedge clk);
    repeat (65535) @(posedge clk);
    @(negedge clk); #1;
    n_tests++; if (fetch_cnt_o !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_max got %h exp ffff", fetch_cnt_o); end
    @(negedge clk); #1;
    n_tests++; if (fetch_cnt_o !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero got %h exp 0000", fetch_cnt_o); end
    @(negedge clk); #1;
    n_tests++; if (fetch_cnt_o !== 16'h0001 || cpu_data_o !== 16'h3443) begin n_fail++; $display("FAIL wrap_run got cnt=%h data=%h exp 0001 3443", fetch_cnt_o, cpu_data_o); end
    // Reset in the middle of a RUN cycle with a fetch in flight.
    rst = 0; #1;
    n_tests++; if (halted_o !== 1'b1 || cpu_stall_o !== 1'b1 || cpu_data_o !== NOP || fetch_cnt_o !== 16'd0)
      begin n_fail++; $display("FAIL rst_mid_run got halted=%b stall=%b data=%h cnt=%h exp 1 1 %h 0000", halted_o, cpu_stall_o, cpu_data_o, fetch_cnt_o, NOP); end
    n_tests++; if (mem_ce_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ce got %b exp 0", mem_ce_o); end
    @(negedge clk); run_i = 0; rst = 1; #1;
    n_tests++; if (cpu_data_o !== NOP || halted_o !== 1'b1) begin n_fail++; $display("FAIL rst_release got data=%h halted=%b exp %h 1", cpu_data_o, halted_o, NOP); end
    // First edge after release already leaves HALT.
    run_i = 1;
    @(negedge clk); #1;
    n_tests++; if (halted_o !== 1'b0 || cpu_data_o !== NOP) begin n_fail++; $display("FAIL rst_first_edge got halted=%b data=%h exp 0 %h", halted_o, cpu_data_o, NOP); end
    run_i = 0; cpu_ce_i = 0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem_rdata_i = 16'h0000;
    test_reset();
    test_load();
    test_run();
    test_step();
    test_conflict();
    test_wrap_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/prog_ctrl.md
PROG_CTRL -- requirements
Module: prog_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16, instruction address width.
REQ-002 Parameter DATA_W, default 16, instruction word width.
REQ-003 Parameter NOP_WORD, default 0, word returned to CPU when no CPU fetch is in flight.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 run_i  in  1  level; high = CPU free-running.
REQ-007 step_i  in  1  pulse; request exactly one CPU fetch while halted.
REQ-008 cpu_ce_i  in  1  CPU fetch enable.
REQ-009 cpu_addr_i  in  ADDR_W  CPU fetch address.
REQ-010 cpu_data_o  out  DATA_W  instruction word to CPU.
REQ-011 cpu_stall_o  out  1  high = CPU must hold PC/pipeline.
REQ-012 dbg_req_i, dbg_we_i  in  1 each  debug access request / write select.
REQ-013 dbg_addr_i  in  ADDR_W; dbg_wdata_i  in  DATA_W  debug address / write data.
REQ-014 dbg_gnt_o  out  1  debug access accepted this cycle.
REQ-015 dbg_rdata_o  out  DATA_W; dbg_rvalid_o  out  1  debug read data / valid.
REQ-016 mem_ce_o, mem_we_o  out  1 each  memory enable / write.
REQ-017 mem_addr_o  out  ADDR_W; mem_wdata_o  out  DATA_W  memory address / write data.
REQ-018 mem_rdata_i  in  DATA_W  memory read data, valid exactly one cycle after an enabled read.
REQ-019 halted_o  out  1  high in HALT state.
REQ-020 fetch_cnt_o  out  16  count of granted CPU fetches.

Function
REQ-021 FSM states HALT, RUN, STEP; shared single-port memory owned by CPU in RUN/STEP, by debug in HALT only.
REQ-022 HALT -> RUN when run_i=1 and dbg_req_i=0; HALT -> STEP when step_i=1, run_i=0, dbg_req_i=0; otherwise stay.
REQ-023 RUN -> HALT when run_i=0; STEP -> HALT unconditionally after one cycle.
REQ-024 Debug priority in HALT: dbg_req_i=1 blocks run/step transitions that cycle; run/step are level/pulse sampled, a step_i blocked by dbg_req_i is dropped.
REQ-025 cpu_stall_o = 1 in HALT, 0 in RUN and STEP (combinational from state).
REQ-026 CPU grant = state in {RUN, STEP} and cpu_ce_i=1: mem_ce_o=1, mem_we_o=0, mem_addr_o=cpu_addr_i.
REQ-027 Debug grant = state HALT and dbg_req_i=1: dbg_gnt_o=1, mem_ce_o=1, mem_we_o=dbg_we_i, mem_addr_o=dbg_addr_i, mem_wdata_o=dbg_wdata_i.
REQ-028 No grant: mem_ce_o=0, mem_we_o=0, mem_addr_o/mem_wdata_o=0.
REQ-029 Registered flag cpu_rd_q = CPU grant of previous cycle; cpu_data_o = mem_rdata_i when cpu_rd_q=1 else NOP_WORD.
REQ-030 A CPU read granted in the last RUN/STEP cycle SHALL still deliver its word in the following (HALT) cycle.
REQ-031 Registered flag dbg_rd_q = debug read grant of previous cycle; dbg_rvalid_o = dbg_rd_q, dbg_rdata_o = mem_rdata_i when valid else 0.
REQ-032 Debug writes produce no dbg_rvalid_o.
REQ-033 fetch_cnt_o increments by 1 per CPU grant, wraps 0xFFFF -> 0x0000; not cleared by state changes.
REQ-034 Exactly one memory access per cycle; CPU and debug grants mutually exclusive by construction.
REQ-035 halted_o = 1 iff state HALT.

Reset
REQ-036 rst=0 asynchronously forces state HALT, cpu_rd_q=0, dbg_rd_q=0, fetch_cnt_o=0.
REQ-037 During reset outputs: halted_o=1, cpu_stall_o=1, cpu_data_o=NOP_WORD, dbg_gnt_o=0, dbg_rvalid_o=0, mem_ce_o=0 unless a combinational debug grant applies.
REQ-038 Reset asserted mid-RUN discards any in-flight CPU read; no cpu_data_o delivery after reset release.
REQ-039 First transition out of HALT occurs at the first rising edge after rst returns high.

Verification
REQ-040 Load: HALT, debug writes 0x3443 @0x0000, 0x1234 @0x0001, read back @0x0001 -> dbg_gnt_o=1 each cycle, dbg_rvalid_o one cycle later with 0x1234, cpu_stall_o=1 throughout.
REQ-041 Run: run_i=1, cpu_ce_i=1, addr 0,1,2 -> cpu_stall_o=0 next cycle, cpu_data_o=0x3443 then 0x1234 one cycle after each address, fetch_cnt_o=3.
REQ-042 Step: HALT, single step_i pulse, addr 0x0000 -> exactly one mem_ce_o, state back to HALT, cpu_data_o=0x3443 in HALT cycle, fetch_cnt_o +1.
REQ-043 Conflict: HALT, dbg_req_i=1 with run_i=1 for 3 cycles then dbg_req_i=0 -> 3 debug grants, no CPU grant, RUN entered on 4th edge.
REQ-044 Wrap/reset: preload fetch_cnt_o to 0xFFFF via 0xFFFF fetches, one more fetch -> 0x0000; assert rst mid-RUN -> halted_o=1 immediately, cpu_data_o=NOP_WORD, fetch_cnt_o=0.
